// File: rtl/axi_ddr_sim_mem_if.sv
// AXI4 bus between the L2 DDR master port and the simulated DDR memory.
// Only the subset of AXI4 fields this memory model uses is carried.
interface axi_ddr_sim_mem_if;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic [2:0]  arsize;
    logic [5:0]  arid;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [5:0]  rid;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic [2:0]  awsize;
    logic [5:0]  awid;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [5:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arlen, arburst, arsize, arid, arvalid, rready,
        output awaddr, awlen, awburst, awsize, awid, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  arready, rdata, rid, rresp, rlast, rvalid,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  araddr, arlen, arburst, arsize, arid, arvalid, rready,
        input  awaddr, awlen, awburst, awsize, awid, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output arready, rdata, rid, rresp, rlast, rvalid,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_ddr_sim_mem.sv
// AXI4 slave memory standing in for the DDR controller: one read and one write
// burst in flight at a time, each with a fixed latency, over a word array.
module axi_ddr_sim_mem #(
    parameter int unsigned DEPTH_WORDS   = 32768,
    parameter int unsigned READ_LATENCY  = 5,
    parameter int unsigned WRITE_LATENCY = 5,
    parameter string       MEMORY_FILE   = ""
) (
    input  logic         clk,
    input  logic         rst,
    axi_ddr_sim_mem_if.slave axi
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [15:0] R_LOAD = 16'(READ_LATENCY - 1);
    localparam logic [15:0] W_LOAD = 16'(WRITE_LATENCY - 1);

    typedef logic [IW-1:0] idx_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_e;

    logic [31:0] mem [DEPTH_WORDS];

    // ---------------- read channel ----------------
    r_state_e    r_state;
    logic [15:0] r_cnt;
    idx_t        r_idx, r_next_idx, ar_idx;
    logic [7:0]  r_left;
    logic [5:0]  r_id;
    logic        r_fixed, r_err, ar_err, ar_hs;
    logic        arready_q, rvalid_q, rlast_q;
    logic [31:0] rdata_q;

    assign ar_idx     = axi.araddr[IW+1:2];
    assign ar_err     = !(axi.arburst == 2'b00 || axi.arburst == 2'b01) || axi.arsize != 3'b010;
    assign ar_hs      = (r_state == R_IDLE) && arready_q && axi.arvalid;
    assign r_next_idx = r_fixed ? r_idx : r_idx + idx_t'(1);

    // NOTE: sequential state uses <= so every register samples pre-edge values;
    // this is also what gives a same-cycle read the old memory contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= R_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_left    <= '0;
            r_id      <= '0;
            r_fixed   <= 1'b0;
            r_err     <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        r_id      <= axi.arid;
                        r_idx     <= ar_idx;
                        r_left    <= axi.arlen;
                        r_fixed   <= (axi.arburst == 2'b00);
                        r_err     <= ar_err;
                        r_cnt     <= R_LOAD;
                        if (READ_LATENCY == 1) begin
                            r_state  <= R_DATA;
                            rvalid_q <= 1'b1;
                            rlast_q  <= (axi.arlen == 8'd0);
                            rdata_q  <= ar_err ? '0 : mem[ar_idx];
                        end else begin
                            r_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    r_cnt <= r_cnt - 16'd1;
                    // Leaving on count 1 lands the first beat exactly READ_LATENCY after AR.
                    if (r_cnt <= 16'd1) begin
                        r_state  <= R_DATA;
                        rvalid_q <= 1'b1;
                        rlast_q  <= (r_left == 8'd0);
                        rdata_q  <= r_err ? '0 : mem[r_idx];
                    end
                end
                R_DATA: begin
                    if (axi.rready) begin
                        if (rlast_q) begin
                            r_state  <= R_IDLE;
                            rvalid_q <= 1'b0;
                            rlast_q  <= 1'b0;
                        end else begin
                            r_idx   <= r_next_idx;
                            r_left  <= r_left - 8'd1;
                            rlast_q <= (r_left == 8'd1);
                            rdata_q <= r_err ? '0 : mem[r_next_idx];
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- write channel ----------------
    w_state_e    w_state;
    logic [15:0] w_cnt;
    idx_t        w_idx, aw_idx;
    logic [7:0]  w_left;
    logic [5:0]  w_id;
    logic        w_fixed, w_err, w_cfg_err, aw_err, aw_hs, w_fire;
    logic        awready_q, wready_q, bvalid_q;

    assign aw_idx = axi.awaddr[IW+1:2];
    assign aw_err = !(axi.awburst == 2'b00 || axi.awburst == 2'b01) || axi.awsize != 3'b010;
    assign aw_hs  = (w_state == W_IDLE) && awready_q && axi.awvalid;
    assign w_fire = !rst && (w_state == W_DATA) && wready_q && axi.wvalid && !w_cfg_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            w_cnt     <= '0;
            w_idx     <= '0;
            w_left    <= '0;
            w_id      <= '0;
            w_fixed   <= 1'b0;
            w_err     <= 1'b0;
            w_cfg_err <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (aw_hs) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_id      <= axi.awid;
                        w_idx     <= aw_idx;
                        w_left    <= axi.awlen;
                        w_fixed   <= (axi.awburst == 2'b00);
                        w_err     <= aw_err;
                        w_cfg_err <= aw_err;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axi.wvalid) begin
                        w_idx  <= w_fixed ? w_idx : w_idx + idx_t'(1);
                        w_left <= w_left - 8'd1;
                        if (w_left == 8'd0) begin
                            // Beat count, not wlast, closes the burst; a missing wlast is only flagged.
                            wready_q <= 1'b0;
                            w_err    <= w_err | ~axi.wlast;
                            w_cnt    <= W_LOAD;
                            if (WRITE_LATENCY == 1) begin
                                w_state  <= W_RESP;
                                bvalid_q <= 1'b1;
                            end else begin
                                w_state <= W_WAIT;
                            end
                        end else begin
                            w_err <= w_err | axi.wlast;
                        end
                    end
                end
                W_WAIT: begin
                    w_cnt <= w_cnt - 16'd1;
                    if (w_cnt <= 16'd1) begin
                        w_state  <= W_RESP;
                        bvalid_q <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (axi.bready) begin
                        bvalid_q <= 1'b0;
                        w_state  <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // NOTE: the array has no reset branch on purpose; contents survive rst.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (axi.wstrb[b]) mem[w_idx][8*b +: 8] <= axi.wdata[8*b +: 8];
            end
        end
    end

    // Outputs are forced low combinationally so they read 0 in the cycle rst is sampled.
    assign axi.arready = arready_q & ~rst;
    assign axi.rvalid  = rvalid_q & ~rst;
    assign axi.rlast   = rlast_q & ~rst;
    assign axi.rdata   = rst ? '0 : rdata_q;
    assign axi.rid     = rst ? '0 : r_id;
    assign axi.rresp   = (!rst && rvalid_q && r_err) ? 2'b10 : 2'b00;
    assign axi.awready = awready_q & ~rst;
    assign axi.wready  = wready_q & ~rst;
    assign axi.bvalid  = bvalid_q & ~rst;
    assign axi.bid     = rst ? '0 : w_id;
    assign axi.bresp   = (!rst && bvalid_q && w_err) ? 2'b10 : 2'b00;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi.araddr[31:IW+2], axi.araddr[1:0],
                                axi.awaddr[31:IW+2], axi.awaddr[1:0]};
endmodule

// File: tb/tb_axi_ddr_sim_mem.sv
// Directed bench for axi_ddr_sim_mem: latency, bursts, strobes, back-pressure,
// error responses, wrap, concurrent channels and reset behaviour.
module tb_axi_ddr_sim_mem;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    axi_ddr_sim_mem_if axi();

    axi_ddr_sim_mem #(
        .DEPTH_WORDS  (32768),
        .READ_LATENCY (5),
        .WRITE_LATENCY(5),
        .MEMORY_FILE  ("")
    ) dut (
        .clk(clk),
        .rst(rst),
        .axi(axi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [5:0]  id;
    } beat_t;

    beat_t beats[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [31:0] base, input logic [3:0] strb, input int wlast_at,
                            input logic [5:0] id, output int aw_cyc, output int lat,
                            output logic [1:0] bresp, output logic [5:0] bid);
        int n;
        axi.awaddr  = addr;
        axi.awlen   = len;
        axi.awburst = burst;
        axi.awsize  = 3'b010;
        axi.awid    = id;
        axi.awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.awready && n < 50);
        if (!axi.awready) check("aw_ready", 32'(axi.awready), 32'd1);
        @(posedge clk); #1;
        aw_cyc = cyc;
        axi.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            axi.wdata  = base + 32'(i);
            axi.wstrb  = strb;
            axi.wlast  = (i == wlast_at);
            axi.wvalid = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!axi.wready && n < 50);
            if (!axi.wready) check("w_ready", 32'(axi.wready), 32'd1);
            @(posedge clk); #1;
        end
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.bvalid && n < 50);
        if (!axi.bvalid) check("b_valid", 32'(axi.bvalid), 32'd1);
        lat   = n;
        bresp = axi.bresp;
        bid   = axi.bid;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [5:0] id, input bit stall,
                           output int ar_cyc, output int lat);
        int    n, k;
        bit    done, first, have_prev;
        beat_t prev, cur;
        beats.delete();
        axi.araddr  = addr;
        axi.arlen   = len;
        axi.arburst = burst;
        axi.arsize  = size;
        axi.arid    = id;
        axi.arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.arready && n < 50);
        if (!axi.arready) check("ar_ready", 32'(axi.arready), 32'd1);
        @(posedge clk); #1;
        ar_cyc = cyc;
        axi.arvalid = 1'b0;
        n = 0; k = 0; lat = 0;
        done = 1'b0; first = 1'b1; have_prev = 1'b0;
        prev = '{default: '0};
        while (!done && n < 200) begin
            axi.rready = stall ? (k % 3 == 0) : 1'b1;
            k++;
            @(negedge clk);
            n++;
            if (have_prev) begin
                check("stall_valid", 32'(axi.rvalid), 32'd1);
                check("stall_data", axi.rdata, prev.data);
                check("stall_last", 32'(axi.rlast), 32'(prev.last));
                have_prev = 1'b0;
            end
            if (axi.rvalid) begin
                if (first) begin lat = n; first = 1'b0; end
                cur = '{data: axi.rdata, resp: axi.rresp, last: axi.rlast, id: axi.rid};
                if (axi.rready) begin
                    beats.push_back(cur);
                    if (cur.last) done = 1'b1;
                end else begin
                    prev = cur;
                    have_prev = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        axi.rready = 1'b1;
        if (!done) check("rd_done", 32'(done), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int awc, arc, wl, rl, nlast, nvalid;
        logic [1:0] br;
        logic [5:0] bi;

        axi.arvalid = 1'b0; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        axi.araddr = '0; axi.arlen = '0; axi.arburst = 2'b01; axi.arsize = 3'b010; axi.arid = '0;
        axi.awaddr = '0; axi.awlen = '0; axi.awburst = 2'b01; axi.awsize = 3'b010; axi.awid = '0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
        axi.rready = 1'b1; axi.bready = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arready", 32'(axi.arready), 32'd0);
        check("rst_awready", 32'(axi.awready), 32'd0);
        check("rst_wready",  32'(axi.wready),  32'd0);
        check("rst_rvalid",  32'(axi.rvalid),  32'd0);
        check("rst_bvalid",  32'(axi.bvalid),  32'd0);
        check("rst_rdata",   axi.rdata,        32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("arready_after_rst", 32'(axi.arready), 32'd1);
        check("awready_after_rst", 32'(axi.awready), 32'd1);
        @(posedge clk); #1;

        // Write then read
        do_write(32'h100, 8'd3, 2'b01, 32'hA0, 4'hF, 3, 6'h0A, awc, wl, br, bi);
        check("wr_lat", 32'(wl), 32'd5);
        check("wr_bresp", 32'(br), 32'd0);
        check("wr_bid", 32'(bi), 32'h0A);
        do_read(32'h100, 8'd3, 2'b01, 3'b010, 6'h15, 1'b0, arc, rl);
        check("rd_lat", 32'(rl), 32'd5);
        check("rd_beats", 32'(beats.size()), 32'd4);
        for (int i = 0; i < beats.size(); i++) begin
            check("rd_data", beats[i].data, 32'hA0 + 32'(i));
            check("rd_last", 32'(beats[i].last), 32'(i == 3));
            check("rd_id", 32'(beats[i].id), 32'h15);
            check("rd_resp", 32'(beats[i].resp), 32'd0);
        end

        // FIXED burst repeats one word
        do_read(32'h104, 8'd2, 2'b00, 3'b010, 6'h01, 1'b0, arc, rl);
        check("fixed_beats", 32'(beats.size()), 32'd3);
        for (int i = 0; i < beats.size(); i++) check("fixed_data", beats[i].data, 32'hA1);

        // Byte strobes
        do_write(32'h200, 8'd0, 2'b01, 32'h11223344, 4'hF, 0, 6'h02, awc, wl, br, bi);
        do_write(32'h200, 8'd0, 2'b01, 32'hAABBCCDD, 4'b0101, 0, 6'h02, awc, wl, br, bi);
        do_read(32'h200, 8'd0, 2'b01, 3'b010, 6'h02, 1'b0, arc, rl);
        check("strb_data", beats[0].data, 32'h11BB33DD);

        // Back-pressure
        do_write(32'h300, 8'd7, 2'b01, 32'hB0, 4'hF, 7, 6'h04, awc, wl, br, bi);
        do_read(32'h300, 8'd7, 2'b01, 3'b010, 6'h04, 1'b1, arc, rl);
        check("bp_beats", 32'(beats.size()), 32'd8);
        nlast = 0;
        for (int i = 0; i < beats.size(); i++) begin
            check("bp_data", beats[i].data, 32'hB0 + 32'(i));
            if (beats[i].last) nlast++;
        end
        check("bp_rlast_count", 32'(nlast), 32'd1);

        // Error responses
        do_read(32'h100, 8'd1, 2'b10, 3'b010, 6'h05, 1'b0, arc, rl);
        check("err_beats", 32'(beats.size()), 32'd2);
        for (int i = 0; i < beats.size(); i++) begin
            check("err_rdata", beats[i].data, 32'd0);
            check("err_rresp", 32'(beats[i].resp), 32'd2);
        end
        do_read(32'h100, 8'd0, 2'b01, 3'b001, 6'h05, 1'b0, arc, rl);
        check("size_err_rresp", 32'(beats[0].resp), 32'd2);
        do_write(32'h400, 8'd3, 2'b01, 32'hE0, 4'hF, 1, 6'h07, awc, wl, br, bi);
        check("early_wlast_bresp", 32'(br), 32'd2);
        check("early_wlast_lat", 32'(wl), 32'd5);
        do_read(32'h400, 8'd3, 2'b01, 3'b010, 6'h07, 1'b0, arc, rl);
        check("early_wlast_beats", 32'(beats.size()), 32'd4);
        check("early_wlast_data3", beats[3].data, 32'hE3);

        // Wrap at the top of memory and ignored upper address bits
        do_write(32'h1FFFC, 8'd1, 2'b01, 32'hC0, 4'hF, 1, 6'h08, awc, wl, br, bi);
        do_read(32'h1FFFC, 8'd1, 2'b01, 3'b010, 6'h08, 1'b0, arc, rl);
        check("wrap_beat1", beats[0].data, 32'hC0);
        check("wrap_beat2", beats[1].data, 32'hC1);
        do_read(32'h0, 8'd0, 2'b01, 3'b010, 6'h08, 1'b0, arc, rl);
        check("wrap_word0", beats[0].data, 32'hC1);
        do_read(32'h20100, 8'd0, 2'b01, 3'b010, 6'h08, 1'b0, arc, rl);
        check("alias_upper_bits", beats[0].data, 32'hA0);

        // Concurrent AR and AW
        repeat (3) @(posedge clk);
        #1;
        fork
            do_write(32'h500, 8'd0, 2'b01, 32'hD0, 4'hF, 0, 6'h03, awc, wl, br, bi);
            do_read(32'h100, 8'd0, 2'b01, 3'b010, 6'h22, 1'b0, arc, rl);
        join
        check("conc_same_cycle", 32'(awc), 32'(arc));
        check("conc_wr_lat", 32'(wl), 32'd5);
        check("conc_rd_lat", 32'(rl), 32'd5);
        check("conc_rd_data", beats[0].data, 32'hA0);
        check("conc_bid", 32'(bi), 32'h03);

        // Reset during R_WAIT
        repeat (2) @(posedge clk);
        #1;
        axi.araddr = 32'h100; axi.arlen = 8'd3; axi.arburst = 2'b01; axi.arsize = 3'b010;
        axi.arid = 6'h09; axi.arvalid = 1'b1;
        nvalid = 0;
        do begin @(negedge clk); nvalid++; end while (!axi.arready && nvalid < 50);
        @(posedge clk); #1 axi.arvalid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_arready", 32'(axi.arready), 32'd0);
        check("midrst_rvalid", 32'(axi.rvalid), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        nvalid = axi.rvalid ? 1 : 0;
        @(negedge clk);
        check("midrst_arready_after", 32'(axi.arready), 32'd1);
        for (int i = 0; i < 15; i++) begin
            if (axi.rvalid) nvalid++;
            @(negedge clk);
        end
        check("midrst_no_rvalid", 32'(nvalid), 32'd0);
        @(posedge clk); #1;
        do_read(32'h100, 8'd3, 2'b01, 3'b010, 6'h0B, 1'b0, arc, rl);
        check("midrst_intact0", beats[0].data, 32'hA0);
        check("midrst_intact3", beats[3].data, 32'hA3);
        do_read(32'h500, 8'd0, 2'b01, 3'b010, 6'h0B, 1'b0, arc, rl);
        check("midrst_intact_conc", beats[0].data, 32'hD0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
